cond_route_sink: RTL
====================

// Module: cond_route_sink
// PURPOSE
//  Clocked, parametrised successor to the conditional-sink flow element.
//  Takes one 4-phase req/ack data channel and one 4-phase control channel.
//  Each control token either steers the data token to one of M output channels,
//  or discards it, acknowledging upstream with no output activity.
//  Sits in condflow between a producer and M consumers; keeps a drop counter
//  and a sticky bad-select flag for debug.
// PARAMETERS
//  N      32  data width, in bits
//  M      2   number of output channels (M >= 1)
//  S      $clog2(M+1)  select width (derived, not overridden)
//  CNT_W  16  width of the drop counter
// PORTS
//  clk       in   1      clock; all state changes on the rising edge
//  rst       in   1      reset, asynchronous, active-low (rst=0 => reset)
//  r_i       in   1      data channel request
//  a_i       out  1      data channel acknowledge
//  d_i       in   N      data; valid while r_i=1
//  r_c       in   1      control channel request
//  a_c       out  1      control channel acknowledge
//  sel_c     in   S      destination: 0..M-1 = output index; M = discard; >M = invalid
//  r_o       out  M      per-output request, one-hot or zero
//  a_o       in   M      per-output acknowledge
//  d_o       out  N      shared output data; stable while any r_o bit is high
//  cnt_clr   in   1      synchronous clear of drop_cnt and err
//  drop_cnt  out  CNT_W  number of tokens discarded; saturates at all-ones
//  err       out  1      sticky flag: some sel_c value was > M
// BEHAVIOUR
//  Reset (rst=0, asynchronous):
//   - Forces state IDLE immediately.
//   - Forces a_i=0, a_c=0, r_o=0, d_o=0, drop_cnt=0, err=0.
//   - If reset lands mid-handshake, the transfer is abandoned. Upstream and
//     downstream must be reset together.
//  FSM, 4-phase protocol, all inputs sampled at clk:
//   IDLE: when r_i=1 and r_c=1, latch d_i into d_o and latch sel_c.
//     - sel<M: go to FWD and raise r_o[sel]. r_o rises 1 cycle after both
//       requests are sampled high.
//     - sel>=M: go to RTZ and raise a_i and a_c together; drop_cnt += 1
//       (saturating). If sel>M, also set err=1.
//     - If only one of r_i or r_c is high, stay in IDLE and do not acknowledge
//       either channel.
//   FWD: hold r_o[sel] and d_o.
//     - On a_o[sel]=1: drop r_o to 0, raise a_i and a_c, go to RTZ.
//     - a_o bits other than sel are ignored.
//   RTZ: hold a_i=a_c=1 until r_i=0, r_c=0, and (for forwarded tokens)
//     a_o[sel]=0 are all sampled. Then drop a_i and a_c and go to IDLE.
//     - The next token is accepted at the earliest 1 cycle after the return
//       to IDLE. There is no overlap between tokens.
//  Latency:
//   - Forwarded token: r_i&r_c -> r_o is 1 cycle; a_o -> a_i/a_c is 1 cycle.
//   - Dropped token: r_i&r_c -> a_i/a_c is 1 cycle.
//  Counter rules:
//   - drop_cnt saturates at 2^CNT_W-1 and does not wrap.
//   - cnt_clr in the same cycle as a drop: clear wins, drop_cnt=0 and err=0.
//   - cnt_clr has no effect on the FSM.
//  Invariants:
//   - At most one r_o bit is high at any time.
//   - a_i == a_c at all times.
//   - d_o changes only in the IDLE->FWD/RTZ transition.
// TESTING
//  1. M=2: sel_c=1, d_i=0xDEADBEEF; respond with a_o[1] after 3 cycles
//     -> r_o=2'b10, d_o=0xDEADBEEF; a_i=a_c=1 one cycle after a_o[1];
//     r_o[0] never rises.
//  2. sel_c=2 (discard), d_i=0x5
//     -> a_i=a_c=1 one cycle later; r_o stays 0; drop_cnt=1; err=0.
//  3. sel_c=3 with M=2
//     -> token dropped; drop_cnt=1; err=1. Then cnt_clr=1 -> drop_cnt=0, err=0.
//  4. r_i=1 held 10 cycles with r_c=0, then r_c=1, sel_c=0
//     -> no acknowledge for the first 10 cycles; r_o[0] rises 1 cycle after r_c.
//  5. CNT_W=4, 17 consecutive discards -> drop_cnt=15 (saturated).
//     Then a discard and cnt_clr in the same cycle -> drop_cnt=0.
//  6. rst=0 asserted in FWD while r_o[1]=1
//     -> r_o, a_i, a_c go to 0 with no clk edge. After release the block is
//     in IDLE and accepts a fresh token.

Source files
------------

// File: rtl/cond_route_sink.sv
// Conditional route/sink: a control token steers a data token to one of M outputs
// or discards it, using 4-phase handshakes on every channel.
module cond_route_sink #(
    parameter int N     = 32,
    parameter int M     = 2,
    parameter int CNT_W = 16,
    localparam int S    = $clog2(M + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r_i,
    output logic             a_i,
    input  logic [N-1:0]     d_i,
    input  logic             r_c,
    output logic             a_c,
    input  logic [S-1:0]     sel_c,
    output logic [M-1:0]     r_o,
    input  logic [M-1:0]     a_o,
    output logic [N-1:0]     d_o,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, FWD, RTZ} state_e;

    state_e             state_q, state_d;
    logic [M-1:0]       ro_q, ro_d;
    logic [M-1:0]       mask_q, mask_d;
    logic               ack_q, ack_d;
    logic [N-1:0]       dout_q, dout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [M-1:0]       selOneHot;
    logic               aoHit;
    logic               dropHit;
    logic               badSel;

    // mask_q remembers the chosen output (all-zero for a discarded token),
    // so a_o[sel] is always read through it and never with an out-of-range index.
    always_comb begin
        selOneHot = '0;
        for (int i = 0; i < M; i++) begin
            selOneHot[i] = (sel_c == S'(i));
        end
    end

    assign aoHit = |(a_o & mask_q);

    always_comb begin
        state_d = state_q;
        ro_d    = ro_q;
        mask_d  = mask_q;
        ack_d   = ack_q;
        dout_d  = dout_q;
        dropHit = 1'b0;
        badSel  = 1'b0;
        case (state_q)
            IDLE: begin
                if (r_i && r_c) begin
                    dout_d = d_i;
                    mask_d = selOneHot;
                    if (sel_c < S'(M)) begin
                        ro_d    = selOneHot;
                        state_d = FWD;
                    end else begin
                        ack_d   = 1'b1;
                        dropHit = 1'b1;
                        badSel  = (sel_c > S'(M));
                        state_d = RTZ;
                    end
                end
            end
            FWD: begin
                if (aoHit) begin
                    ro_d    = '0;
                    ack_d   = 1'b1;
                    state_d = RTZ;
                end
            end
            RTZ: begin
                if (!r_i && !r_c && !aoHit) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                ro_d    = '0;
                ack_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // A clear in the same cycle as a drop takes priority over the increment.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (cnt_clr) begin
            cnt_d = '0;
            err_d = 1'b0;
        end else begin
            if (dropHit && (cnt_q != '1)) begin
                cnt_d = cnt_q + 1'b1;
            end
            err_d = err_q | badSel;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ro_q    <= '0;
            mask_q  <= '0;
            ack_q   <= 1'b0;
            dout_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ro_q    <= ro_d;
            mask_q  <= mask_d;
            ack_q   <= ack_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign a_i      = ack_q;
    assign a_c      = ack_q;
    assign r_o      = ro_q;
    assign d_o      = dout_q;
    assign drop_cnt = cnt_q;
    assign err      = err_q;

endmodule
